com_word_tx: RTL and testbench
==============================

Name: com_word_tx

Overview:
- UART transmit path of the host link. Serializes a 1–4 byte response word (PC, load data, status) onto `tx` as 8N1 frames.
- Mirror of the com_controller receive path, which assembles bytes into a 32-bit word.
- Sits between com_controller response logic and the `tx` pin, in the `clk_div` domain.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (minimum 2).
- DATA_W, 32, width of `send_data`. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  system clock (`clk_div`)
- reset  input  1  asynchronous, active-low reset
- send_valid  input  1  request to transmit `send_data`
- send_data  input  32  word to send; byte 0 = bits [7:0]
- send_len  input  3  number of bytes to send, 1–4; 0 is treated as 4, 5–7 are treated as 4
- send_ready  output  1  block can accept a request this cycle
- busy  output  1  frame sequence in progress
- done  output  1  one-cycle pulse when the last stop bit completes
- tx  output  1  serial line, idle high

Behaviour:
- Reset (`reset`=0, asynchronous): state=IDLE, `tx`=1, `send_ready`=1, `busy`=0, `done`=0, all counters 0. Applies immediately, including mid-bit or mid-frame; the partial frame is abandoned and nothing resumes after reset releases.
- Handshake:
  - A request is accepted on a rising edge where `send_valid`=1 and `send_ready`=1.
  - `send_data` and the effective length are latched at that edge; later changes to the inputs are ignored.
  - `send_valid` while `send_ready`=0 is ignored and not queued.
- `send_ready` = 1 in IDLE only. `busy` = 1 in START, DATA and STOP.
- State machine (registered; `tx` driven from a register, glitch-free):
  - IDLE: `tx`=1. On accept -> START, byte_idx=0, bit_cnt=0, baud_cnt=0.
  - START: `tx`=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: `tx`=current byte bit[bit_cnt], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7 -> STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx < len-1: byte_idx+1, go to START with no idle gap.
    - else: go to IDLE and assert `done`=1 for exactly that one cycle.
- Byte order: byte 0 (`send_data[7:0]`) first, then [15:8], [23:16], [31:24], up to the effective length.
- Latency: `tx` falls on the same edge the request is accepted; the first `tx`=0 cycle is the cycle after the accept edge.
- Total busy time = len × 10 × CLKS_PER_BIT cycles.
- Back-to-back: during the `done` cycle the state is IDLE and `send_ready`=1. A request accepted on the next edge starts its start bit immediately, with zero idle bits between words.
- `baud_cnt` counts 0..CLKS_PER_BIT-1 and wraps; the bit advances on wrap.
- `bit_cnt` is 3 bits, 0..7.
- `byte_idx` is 2 bits, 0..3.

Test Plan:
- Single word, CLKS_PER_BIT=4, `send_data`=0x000000A5, `send_len`=1:
  - `tx` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - `done` pulses 40 cycles after accept.
  - `busy` high for exactly 40 cycles.
- Full word, `send_data`=0xDEADBEEF, `send_len`=4 (and repeat with `send_len`=0):
  - receiver model decodes bytes EF, BE, AD, DE in that order.
  - 160 busy cycles; no idle bits between bytes.
- Ignored requests: pulse `send_valid` with 0x12345678 while `busy`=1.
  - no extra bytes transmitted.
  - the original frame is unchanged.
  - `send_ready` stays 0 until `done`.
- Back-to-back: hold `send_valid`=1 with 0x11, then 0x22, `send_len`=1.
  - second start bit begins on the cycle after the `done` cycle.
  - line shows 0x11 then 0x22 with no idle bit.
- Reset mid-frame: assert `reset`=0 during bit 3 of byte 1.
  - `tx`=1 and `busy`=0 asynchronously, with no clock edge needed.
  - after release, `send_ready`=1 and no residual bits are emitted.
- Input stability: change `send_data` to 0xFFFFFFFF one cycle after accepting 0x00000000 with `send_len`=2.
  - transmitted bytes are 00, 00.

Source files
------------

// File: rtl/com_word_tx.sv
// UART 8N1 transmitter for host-link responses: sends bytes 0..len-1 of a
// 32-bit word LSB-first, back-to-back, with no idle bits between bytes.
module com_word_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send_valid,
    input  logic [DATA_W-1:0] send_data,
    input  logic [2:0]        send_len,
    output logic              send_ready,
    output logic              busy,
    output logic              done,
    output logic              tx
);

    localparam int            CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        last_q;
    logic [1:0]        byte_idx_q;
    logic [2:0]        bit_cnt_q;
    logic [CW-1:0]     baud_q;
    logic              tx_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;

    logic              baud_wrap_d;
    logic [2:0]        bit_nxt_d;
    logic [7:0]        cur_byte_d;
    logic [1:0]        len_last_d;

    always_comb begin
        baud_wrap_d = (baud_q == BAUD_LAST);
        bit_nxt_d   = bit_cnt_q + 3'd1;
        cur_byte_d  = data_q[{byte_idx_q, 3'b000} +: 8];
        // Index of the final byte; 0 and 5..7 all mean a full 4-byte word.
        unique case (send_len)
            3'd1:    len_last_d = 2'd0;
            3'd2:    len_last_d = 2'd1;
            3'd3:    len_last_d = 2'd2;
            default: len_last_d = 2'd3;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            last_q     <= '0;
            byte_idx_q <= '0;
            bit_cnt_q  <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (send_valid) begin
                        data_q     <= send_data;
                        last_q     <= len_last_d;
                        byte_idx_q <= '0;
                        bit_cnt_q  <= '0;
                        baud_q     <= '0;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (baud_wrap_d) begin
                        baud_q  <= '0;
                        tx_q    <= cur_byte_d[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap_d) begin
                        baud_q    <= '0;
                        bit_cnt_q <= bit_nxt_d;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tx_q <= cur_byte_d[bit_nxt_d];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_wrap_d) begin
                        baud_q <= '0;
                        if (byte_idx_q != last_q) begin
                            // Next start bit follows the stop bit directly.
                            byte_idx_q <= byte_idx_q + 2'd1;
                            bit_cnt_q  <= '0;
                            tx_q       <= 1'b0;
                            state_q    <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx         = tx_q;
    assign send_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_com_word_tx.sv
// Scoreboarded bench: a word-level model predicts bytes, frame start times and
// handshake flags; a UART receiver model decodes the line and checks them.
module tb_com_word_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        send_valid = 1'b0;
    logic [31:0] send_data = '0;
    logic [2:0]  send_len = 3'd1;
    logic        send_ready, busy, done, tx;

    com_word_tx #(.CLKS_PER_BIT(CPB), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .send_valid(send_valid), .send_data(send_data),
        .send_len(send_len), .send_ready(send_ready), .busy(busy), .done(done), .tx(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        int unsigned start;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          rem = 0;
    bit          exp_done = 1'b0;
    int          acc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int eff_len(input logic [2:0] l);
        return (l == 3'd0 || l > 3'd4) ? 4 : int'(l);
    endfunction

    // Word-level model: a word occupies the link for len*10*CPB cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem      = 0;
            exp_done = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            exp_done = 1'b0;
            if (rem == 0) begin
                if (send_valid) begin
                    int l;
                    l = eff_len(send_len);
                    for (int k = 0; k < l; k++) begin
                        exp_t e;
                        e.b     = send_data[8*k +: 8];
                        e.start = cyc + k * 10 * CPB;
                        exp_q.push_back(e);
                    end
                    rem = l * 10 * CPB;
                    acc_cnt++;
                end
            end else begin
                rem--;
                if (rem == 0) exp_done = 1'b1;
            end
        end
    end

    // Monitor: flag checks plus a mid-bit sampling receiver.
    int         rx_cyc = -1;
    logic [7:0] rx_b = '0;
    always @(negedge clk) begin
        chk("send_ready", send_ready, rem == 0);
        chk("busy", busy, rem != 0);
        chk("done", done, exp_done);
        if (!reset) begin
            rx_cyc = -1;
        end else if (rx_cyc < 0) begin
            if (tx === 1'b0) begin
                rx_cyc = 0;
                chk("start_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("start_cycle", cyc, exp_q[0].start);
            end
        end else begin
            rx_cyc++;
            if (rx_cyc % CPB == CPB / 2) begin
                int idx;
                idx = rx_cyc / CPB;
                if (idx == 0) chk("start_bit", tx, 0);
                else if (idx <= 8) rx_b[idx-1] = tx;
                else begin
                    chk("stop_bit", tx, 1);
                    if (exp_q.size() > 0) begin
                        chk("rx_byte", rx_b, exp_q[0].b);
                        void'(exp_q.pop_front());
                    end
                    rx_cyc = -1;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (rem != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", rem, 0);
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", acc_cnt >= target, 1);
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] l, input logic [31:0] after);
        @(negedge clk);
        send_valid = 1'b1;
        send_data  = d;
        send_len   = l;
        @(negedge clk);
        send_valid = 1'b0;
        send_data  = after;
    endtask

    task automatic pulse_junk(input logic [31:0] d);
        @(negedge clk);
        send_valid = 1'b1;
        send_data  = d;
        @(negedge clk);
        send_valid = 1'b0;
    endtask

    initial begin
        int a0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_ready", send_ready, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte, then full words with len 4 and len 0.
        a0 = acc_cnt;
        send(32'h0000_00A5, 3'd1, 32'h0000_00A5);
        wait_idle();
        chk("accept_a5", acc_cnt, a0 + 1);
        send(32'hDEAD_BEEF, 3'd4, 32'h0);
        wait_idle();
        send(32'hDEAD_BEEF, 3'd0, 32'h0);
        wait_idle();

        // Requests while busy are dropped.
        a0 = acc_cnt;
        send(32'hCAFE_F00D, 3'd4, 32'h0);
        repeat (20) @(negedge clk);
        pulse_junk(32'h1234_5678);
        repeat (60) @(negedge clk);
        pulse_junk(32'h1234_5678);
        wait_idle();
        chk("ignored_requests", acc_cnt, a0 + 1);

        // Back-to-back with send_valid held high.
        a0 = acc_cnt;
        @(negedge clk);
        send_valid = 1'b1;
        send_data  = 32'h11;
        send_len   = 3'd1;
        wait_acc(a0 + 1);
        send_data = 32'h22;
        wait_acc(a0 + 2);
        send_valid = 1'b0;
        wait_idle();

        // Reset during bit 3 of byte 1.
        send(32'h89AB_CDEF, 3'd4, 32'h0);
        repeat (57) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_tx", tx, 1);
        chk("async_busy", busy, 0);
        chk("async_ready", send_ready, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_reset_ready", send_ready, 1);

        // Input stability after accept.
        send(32'h0, 3'd2, 32'hFFFF_FFFF);
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = $urandom_range(0, 3);
            send($urandom, 3'($urandom_range(0, 7)), $urandom);
            if (mode == 1) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
                pulse_junk($urandom);
            end
            if (mode != 2) wait_idle();
        end

        wait_idle();
        repeat (60) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
